// File: rtl/uart_host_ctrl_if.sv
// Purpose : host-side signal bundle for uart_host_ctrl: upstream TX byte stream, downstream RX
//           byte stream with error flags, error counter, and the UART CSN/WEN/OEN byte interface.
// Latency : none (wires only). Backpressure: TX_VALID/TX_READY and RX_VALID/RX_READY handshakes.
//
// Signals:
//   TX_DATA/TX_VALID/TX_READY     upstream byte stream into the controller
//   RX_DATA/RX_ERR/RX_VALID/RX_READY  downstream byte stream with {FRAMING,PARITY,OVERFLOW}
//   ERR_CNT/CLR_ERR               saturating count of errored bytes, and its clear
//   CSN/WEN/OEN/UART_DIN          strobes and write data towards the UART core
//   UART_DOUT/TXRDY/RXRDY/PARITY_ERR/FRAMING_ERR/OVERFLOW  read data and status from the UART
// modport master : the controller. modport slave : the surrounding logic and UART core.
interface uart_host_ctrl_if #(
    parameter int ERR_CNT_W = 8
);
    logic [7:0]           TX_DATA;
    logic                 TX_VALID;
    logic                 TX_READY;
    logic [7:0]           RX_DATA;
    logic                 RX_VALID;
    logic                 RX_READY;
    logic [2:0]           RX_ERR;
    logic [ERR_CNT_W-1:0] ERR_CNT;
    logic                 CLR_ERR;
    logic                 CSN;
    logic                 WEN;
    logic                 OEN;
    logic [7:0]           UART_DIN;
    logic [7:0]           UART_DOUT;
    logic                 TXRDY;
    logic                 RXRDY;
    logic                 PARITY_ERR;
    logic                 FRAMING_ERR;
    logic                 OVERFLOW;

    modport master (
        input  TX_DATA, TX_VALID, RX_READY, CLR_ERR,
        input  UART_DOUT, TXRDY, RXRDY, PARITY_ERR, FRAMING_ERR, OVERFLOW,
        output TX_READY, RX_DATA, RX_VALID, RX_ERR, ERR_CNT,
        output CSN, WEN, OEN, UART_DIN
    );

    modport slave (
        output TX_DATA, TX_VALID, RX_READY, CLR_ERR,
        output UART_DOUT, TXRDY, RXRDY, PARITY_ERR, FRAMING_ERR, OVERFLOW,
        input  TX_READY, RX_DATA, RX_VALID, RX_ERR, ERR_CNT,
        input  CSN, WEN, OEN, UART_DIN
    );
endinterface

// File: rtl/uart_host_ctrl.sv
// Purpose : host initiator for a UART byte interface; moves upstream bytes into the UART
//           transmitter and drains received bytes (plus error flags) to a downstream stream.
// Latency : write strobes 1 cycle after IDLE accepts; read data valid RD_HOLD cycles after read start.
// Backpressure: RX_VALID held until RX_READY; no new read while RX_VALID is set; TX_READY only
//               pulses in the single WRITE cycle.
//
// Ports:
//   CLK    clock
//   RESET  synchronous, active-high reset; aborts any access in flight
//   bus    uart_host_ctrl_if.master, carrying the TX/RX streams, error counter and UART strobes
module uart_host_ctrl #(
    parameter int RD_HOLD   = 2,
    parameter int GAP_CYC   = 2,
    parameter int ERR_CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    uart_host_ctrl_if.master bus
);
    // One down-counter serves both the read hold and the post-access gap.
    localparam int MAX_CYC = (RD_HOLD > GAP_CYC) ? RD_HOLD : GAP_CYC;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(RD_HOLD - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_GAP
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 csn_q, csn_d;
    logic                 wen_q, wen_d;
    logic                 oen_q, oen_d;
    logic [7:0]           din_q, din_d;
    logic                 tx_ready_q, tx_ready_d;
    logic                 capture;

    logic [7:0]           rx_data_q;
    logic [2:0]           rx_err_q;
    logic                 rx_valid_q;
    logic [ERR_CNT_W-1:0] err_cnt_q;

    logic [2:0]           status_flags;
    logic                 err_inc;

    assign status_flags = {bus.FRAMING_ERR, bus.PARITY_ERR, bus.OVERFLOW};
    assign err_inc      = capture && (|status_flags);

    // State register and registered strobes.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            csn_q      <= 1'b1;
            wen_q      <= 1'b1;
            oen_q      <= 1'b1;
            din_q      <= 8'h00;
            tx_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            csn_q      <= csn_d;
            wen_q      <= wen_d;
            oen_q      <= oen_d;
            din_q      <= din_d;
            tx_ready_q <= tx_ready_d;
        end
    end

    // Next state and next strobe values. Strobes default high so every path out of an
    // access releases them on the following cycle.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        csn_d      = 1'b1;
        wen_d      = 1'b1;
        oen_d      = 1'b1;
        din_d      = din_q;
        tx_ready_d = 1'b0;
        capture    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Draining the receiver wins over transmitting, but only when the
                // output slot is empty; the UART keeps buffering meanwhile.
                if (bus.RXRDY && !rx_valid_q) begin
                    state_d = ST_READ;
                    cnt_d   = RD_LAST;
                    csn_d   = 1'b0;
                    oen_d   = 1'b0;
                end else if (bus.TXRDY && bus.TX_VALID) begin
                    state_d    = ST_WRITE;
                    csn_d      = 1'b0;
                    wen_d      = 1'b0;
                    din_d      = bus.TX_DATA;
                    tx_ready_d = 1'b1;
                end
            end
            ST_WRITE: begin
                state_d = ST_GAP;
                cnt_d   = GAP_LAST;
            end
            ST_READ: begin
                if (cnt_q == '0) begin
                    // Last hold cycle: UART_DOUT is sampled on this edge.
                    capture = 1'b1;
                    state_d = ST_GAP;
                    cnt_d   = GAP_LAST;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    csn_d = 1'b0;
                    oen_d = 1'b0;
                end
            end
            ST_GAP: begin
                // Lets the UART refresh TXRDY/RXRDY before IDLE looks at them again.
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Received-byte holding register and error counter.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            rx_data_q  <= 8'h00;
            rx_err_q   <= 3'b000;
            rx_valid_q <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            // A capture can only happen while rx_valid_q is low, so the two branches
            // never compete for the same byte.
            if (capture) begin
                rx_data_q  <= bus.UART_DOUT;
                rx_err_q   <= status_flags;
                rx_valid_q <= 1'b1;
            end else if (rx_valid_q && bus.RX_READY) begin
                rx_valid_q <= 1'b0;
            end

            // A clear coinciding with an errored capture still counts that byte.
            if (bus.CLR_ERR) begin
                err_cnt_q <= err_inc ? ERR_CNT_W'(1) : '0;
            end else if (err_inc && (err_cnt_q != '1)) begin
                err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
            end
        end
    end

    assign bus.CSN      = csn_q;
    assign bus.WEN      = wen_q;
    assign bus.OEN      = oen_q;
    assign bus.UART_DIN = din_q;
    assign bus.TX_READY = tx_ready_q;
    assign bus.RX_DATA  = rx_data_q;
    assign bus.RX_ERR   = rx_err_q;
    assign bus.RX_VALID = rx_valid_q;
    assign bus.ERR_CNT  = err_cnt_q;
endmodule

// File: tb/tb_uart_host_ctrl.sv
// Purpose : self-checking bench for uart_host_ctrl; directed scenarios plus randomized traffic
//           checked against a queue-based model of the UART and both byte streams.
// Latency : n/a. Backpressure: downstream RX_READY and UART TXRDY are toggled by the bench.
module tb_uart_host_ctrl;
    localparam int RD_HOLD    = 2;
    localparam int GAP_CYC    = 2;
    localparam int ERR_CNT_W  = 8;
    localparam int WR_SPACING = 2 + GAP_CYC;
    localparam int N_RAND     = 40;

    logic CLK = 1'b0;
    logic RESET;
    int   checks   = 0;
    int   failures = 0;

    uart_host_ctrl_if #(.ERR_CNT_W(ERR_CNT_W)) bus ();

    uart_host_ctrl #(
        .RD_HOLD  (RD_HOLD),
        .GAP_CYC  (GAP_CYC),
        .ERR_CNT_W(ERR_CNT_W)
    ) dut (
        .CLK  (CLK),
        .RESET(RESET),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_flags(input logic [2:0] f);
        {bus.FRAMING_ERR, bus.PARITY_ERR, bus.OVERFLOW} = f;
    endtask

    task automatic idle_inputs();
        bus.TX_DATA   = 8'h00;
        bus.TX_VALID  = 1'b0;
        bus.RX_READY  = 1'b0;
        bus.CLR_ERR   = 1'b0;
        bus.UART_DOUT = 8'h00;
        bus.TXRDY     = 1'b0;
        bus.RXRDY     = 1'b0;
        set_flags(3'b000);
    endtask

    task automatic settle();
        idle_inputs();
        repeat (GAP_CYC + RD_HOLD + 2) tick();
    endtask

    // Acts as the UART for one read: offers a byte, withdraws RXRDY once the read strobe is
    // seen, optionally raises CLR_ERR for the capture edge. Returns with the byte captured.
    task automatic do_read(input logic [7:0] d, input logic [2:0] f, input bit clr, output bit ok);
        ok = 1'b0;
        bus.UART_DOUT = d;
        set_flags(f);
        bus.RXRDY = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (bus.OEN === 1'b0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        bus.RXRDY = 1'b0;
        if (!ok) return;
        for (int k = 1; k < RD_HOLD; k++) tick();
        bus.CLR_ERR = clr;
        tick();
        bus.CLR_ERR = 1'b0;
    endtask

    task automatic accept_rx();
        bus.RX_READY = 1'b1;
        tick();
        bus.RX_READY = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        idle_inputs();
        bus.UART_DOUT = 8'hFF;
        tick();
        tick();
        checks++;
        if ({bus.CSN, bus.WEN, bus.OEN} !== 3'b111) begin
            failures++; $display("FAIL reset_strobes: got %b expected 111", {bus.CSN, bus.WEN, bus.OEN});
        end
        checks++;
        if (bus.UART_DIN !== 8'h00 || bus.TX_READY !== 1'b0) begin
            failures++; $display("FAIL reset_tx: din=%h tx_ready=%b expected 00/0", bus.UART_DIN, bus.TX_READY);
        end
        checks++;
        if (bus.RX_VALID !== 1'b0 || bus.RX_DATA !== 8'h00 || bus.RX_ERR !== 3'b000) begin
            failures++; $display("FAIL reset_rx: valid=%b data=%h err=%b expected 0/00/000", bus.RX_VALID, bus.RX_DATA, bus.RX_ERR);
        end
        checks++;
        if (bus.ERR_CNT !== 8'h00) begin
            failures++; $display("FAIL reset_err_cnt: got %h expected 00", bus.ERR_CNT);
        end
        RESET = 1'b0;
    endtask

    task automatic test_write();
        int busy = 0;
        settle();
        bus.TX_DATA  = 8'hA5;
        bus.TX_VALID = 1'b1;
        bus.TXRDY    = 1'b1;
        tick();
        checks++;
        if ({bus.CSN, bus.WEN, bus.OEN} !== 3'b001 || bus.UART_DIN !== 8'hA5 || bus.TX_READY !== 1'b1) begin
            failures++; $display("FAIL write_strobe: csn/wen/oen=%b din=%h rdy=%b expected 001/a5/1", {bus.CSN, bus.WEN, bus.OEN}, bus.UART_DIN, bus.TX_READY);
        end
        tick();
        bus.TX_VALID = 1'b0;
        checks++;
        if ({bus.CSN, bus.WEN, bus.OEN} !== 3'b111 || bus.TX_READY !== 1'b0) begin
            failures++; $display("FAIL write_release: csn/wen/oen=%b rdy=%b expected 111/0", {bus.CSN, bus.WEN, bus.OEN}, bus.TX_READY);
        end
        repeat (GAP_CYC + 2) begin
            tick();
            if (bus.CSN === 1'b0 || bus.TX_READY === 1'b1) busy++;
        end
        checks++;
        if (busy != 0) begin
            failures++; $display("FAIL write_no_extra: got %0d busy cycles expected 0", busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] src[5];
        logic [7:0] got[$];
        int         wr_cyc[$];
        int         idx = 0;
        int         bad_sp = 0;
        int         bad_dat = 0;
        bit         drop = 1'b0;
        settle();
        foreach (src[i]) src[i] = 8'($urandom);
        bus.TX_DATA  = src[0];
        bus.TX_VALID = 1'b1;
        bus.TXRDY    = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            tick();
            if (drop) begin
                drop = 1'b0;
                idx++;
                if (idx < 5) bus.TX_DATA = src[idx];
                else bus.TX_VALID = 1'b0;
            end
            if (bus.WEN === 1'b0) begin
                got.push_back(bus.UART_DIN);
                wr_cyc.push_back(c);
            end
            if (bus.TX_VALID && bus.TX_READY === 1'b1) drop = 1'b1;
        end
        checks++;
        if (got.size() != 5) begin
            failures++; $display("FAIL b2b_count: got %0d writes expected 5", got.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (got[i] !== src[i]) bad_dat++;
                if (i > 0 && wr_cyc[i] - wr_cyc[i-1] != WR_SPACING) bad_sp++;
            end
            checks++;
            if (bad_dat != 0) begin
                failures++; $display("FAIL b2b_data: %0d wrong bytes expected 0", bad_dat);
            end
            checks++;
            if (bad_sp != 0) begin
                failures++; $display("FAIL b2b_spacing: %0d gaps differ from %0d cycles", bad_sp, WR_SPACING);
            end
        end
    endtask

    task automatic test_tx_drop();
        int busy = 0;
        settle();
        bus.TX_DATA  = 8'h5A;
        bus.TX_VALID = 1'b1;
        repeat (3) tick();
        bus.TX_VALID = 1'b0;
        bus.TXRDY    = 1'b1;
        repeat (8) begin
            tick();
            if (bus.WEN === 1'b0 || bus.TX_READY === 1'b1) busy++;
        end
        checks++;
        if (busy != 0) begin
            failures++; $display("FAIL tx_drop: got %0d write cycles expected 0", busy);
        end
    endtask

    task automatic test_read();
        int bad = 0;
        settle();
        bus.UART_DOUT = 8'h3C;
        bus.RXRDY     = 1'b1;
        tick();
        bus.RXRDY = 1'b0;
        if ({bus.CSN, bus.WEN, bus.OEN} !== 3'b010) bad++;
        for (int k = 1; k < RD_HOLD; k++) begin
            tick();
            if ({bus.CSN, bus.WEN, bus.OEN} !== 3'b010) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++; $display("FAIL read_hold: %0d of %0d cycles without CSN/OEN low", bad, RD_HOLD);
        end
        tick();
        checks++;
        if ({bus.CSN, bus.WEN, bus.OEN} !== 3'b111 || bus.RX_VALID !== 1'b1 || bus.RX_DATA !== 8'h3C || bus.RX_ERR !== 3'b000) begin
            failures++; $display("FAIL read_capture: strobes=%b valid=%b data=%h err=%b expected 111/1/3c/000", {bus.CSN, bus.WEN, bus.OEN}, bus.RX_VALID, bus.RX_DATA, bus.RX_ERR);
        end
        bus.UART_DOUT = 8'h00;
        set_flags(3'b111);
        bad = 0;
        repeat (10) begin
            tick();
            if (bus.RX_VALID !== 1'b1 || bus.RX_DATA !== 8'h3C || bus.RX_ERR !== 3'b000) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++; $display("FAIL read_held: %0d unstable cycles expected 0", bad);
        end
        accept_rx();
        checks++;
        if (bus.RX_VALID !== 1'b0) begin
            failures++; $display("FAIL read_accept: valid=%b expected 0", bus.RX_VALID);
        end
    endtask

    task automatic test_priority();
        int         first_rd = -1;
        int         first_wr = -1;
        logic [7:0] wr_byte = 8'h00;
        logic [7:0] rx_byte = 8'h00;
        bit         got_rx = 1'b0;
        bit         drop = 1'b0;
        settle();
        bus.UART_DOUT = 8'h77;
        bus.RXRDY     = 1'b1;
        bus.TX_DATA   = 8'h11;
        bus.TX_VALID  = 1'b1;
        bus.TXRDY     = 1'b1;
        bus.RX_READY  = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (drop) begin
                bus.TX_VALID = 1'b0;
                drop = 1'b0;
            end
            if (bus.OEN === 1'b0 && first_rd < 0) begin
                first_rd  = c;
                bus.RXRDY = 1'b0;
            end
            if (bus.WEN === 1'b0 && first_wr < 0) begin
                first_wr = c;
                wr_byte  = bus.UART_DIN;
            end
            if (bus.RX_VALID === 1'b1 && bus.RX_READY) begin
                rx_byte = bus.RX_DATA;
                got_rx  = 1'b1;
            end
            if (bus.TX_VALID && bus.TX_READY === 1'b1) drop = 1'b1;
        end
        bus.RX_READY = 1'b0;
        checks++;
        if (first_rd != 1) begin
            failures++; $display("FAIL prio_read_first: read at cycle %0d expected 1", first_rd);
        end
        checks++;
        if (first_wr != RD_HOLD + GAP_CYC + 2 || wr_byte !== 8'h11) begin
            failures++; $display("FAIL prio_write_after: write at %0d byte %h expected %0d/11", first_wr, wr_byte, RD_HOLD + GAP_CYC + 2);
        end
        checks++;
        if (!got_rx || rx_byte !== 8'h77) begin
            failures++; $display("FAIL prio_rx_byte: got=%b byte=%h expected 1/77", got_rx, rx_byte);
        end
    endtask

    task automatic test_err_sat();
        bit ok;
        int timeouts = 0;
        int bad_err = 0;
        int bad_cnt = 0;
        int expv;
        settle();
        bus.CLR_ERR = 1'b1;
        tick();
        bus.CLR_ERR = 1'b0;
        for (int n = 1; n <= 300; n++) begin
            do_read(8'($urandom), 3'b010, 1'b0, ok);
            if (!ok) timeouts++;
            if (bus.RX_VALID !== 1'b1 || bus.RX_ERR !== 3'b010) bad_err++;
            expv = (n > 255) ? 255 : n;
            if (bus.ERR_CNT !== ERR_CNT_W'(expv)) bad_cnt++;
            accept_rx();
        end
        checks++;
        if (timeouts != 0) begin
            failures++; $display("FAIL err_read_timeout: %0d reads never started expected 0", timeouts);
        end
        checks++;
        if (bad_err != 0) begin
            failures++; $display("FAIL err_flags: %0d captures with wrong RX_ERR expected 0", bad_err);
        end
        checks++;
        if (bad_cnt != 0) begin
            failures++; $display("FAIL err_count_track: %0d reads with wrong ERR_CNT expected 0", bad_cnt);
        end
        checks++;
        if (bus.ERR_CNT !== 8'hFF) begin
            failures++; $display("FAIL err_saturate: got %h expected ff", bus.ERR_CNT);
        end
        do_read(8'h21, 3'b010, 1'b1, ok);
        checks++;
        if (!ok || bus.ERR_CNT !== 8'h01) begin
            failures++; $display("FAIL err_clr_with_inc: got %h ok=%b expected 01", bus.ERR_CNT, ok);
        end
        accept_rx();
        do_read(8'h22, 3'b100, 1'b0, ok);
        checks++;
        if (bus.RX_ERR !== 3'b100 || bus.ERR_CNT !== 8'h02) begin
            failures++; $display("FAIL err_framing: err=%b cnt=%h expected 100/02", bus.RX_ERR, bus.ERR_CNT);
        end
        accept_rx();
        do_read(8'h23, 3'b001, 1'b0, ok);
        checks++;
        if (bus.RX_ERR !== 3'b001 || bus.ERR_CNT !== 8'h03) begin
            failures++; $display("FAIL err_overflow: err=%b cnt=%h expected 001/03", bus.RX_ERR, bus.ERR_CNT);
        end
        accept_rx();
        do_read(8'h24, 3'b000, 1'b0, ok);
        checks++;
        if (bus.RX_DATA !== 8'h24 || bus.ERR_CNT !== 8'h03) begin
            failures++; $display("FAIL err_clean_byte: data=%h cnt=%h expected 24/03", bus.RX_DATA, bus.ERR_CNT);
        end
        accept_rx();
        bus.CLR_ERR = 1'b1;
        tick();
        bus.CLR_ERR = 1'b0;
        checks++;
        if (bus.ERR_CNT !== 8'h00) begin
            failures++; $display("FAIL err_clr_alone: got %h expected 00", bus.ERR_CNT);
        end
    endtask

    task automatic test_reset_mid_read();
        bit ok;
        settle();
        do_read(8'h99, 3'b001, 1'b0, ok);
        checks++;
        if (bus.ERR_CNT !== 8'h01) begin
            failures++; $display("FAIL rst_pre_cnt: got %h expected 01", bus.ERR_CNT);
        end
        accept_rx();
        bus.UART_DOUT = 8'h66;
        bus.RXRDY     = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.OEN === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        tick();
        checks++;
        if (!ok || bus.OEN !== 1'b0) begin
            failures++; $display("FAIL rst_in_read: started=%b oen=%b expected 1/0", ok, bus.OEN);
        end
        RESET = 1'b1;
        tick();
        checks++;
        if ({bus.CSN, bus.WEN, bus.OEN} !== 3'b111 || bus.RX_VALID !== 1'b0 || bus.ERR_CNT !== 8'h00) begin
            failures++; $display("FAIL rst_abort: strobes=%b valid=%b cnt=%h expected 111/0/00", {bus.CSN, bus.WEN, bus.OEN}, bus.RX_VALID, bus.ERR_CNT);
        end
        bus.RXRDY    = 1'b0;
        bus.TX_DATA  = 8'hC3;
        bus.TX_VALID = 1'b1;
        bus.TXRDY    = 1'b1;
        RESET        = 1'b0;
        tick();
        checks++;
        if (bus.WEN !== 1'b0 || bus.UART_DIN !== 8'hC3) begin
            failures++; $display("FAIL rst_to_idle: wen=%b din=%h expected 0/c3", bus.WEN, bus.UART_DIN);
        end
        tick();
        bus.TX_VALID = 1'b0;
    endtask

    task automatic test_rx_backpressure();
        bit ok;
        int oen_low = 0;
        int bad = 0;
        settle();
        do_read(8'h42, 3'b000, 1'b0, ok);
        bus.UART_DOUT = 8'h43;
        bus.RXRDY     = 1'b1;
        repeat (50) begin
            tick();
            if (bus.OEN === 1'b0) oen_low++;
            if (bus.RX_VALID !== 1'b1 || bus.RX_DATA !== 8'h42) bad++;
        end
        checks++;
        if (!ok || oen_low != 0) begin
            failures++; $display("FAIL bp_no_read: ok=%b oen_low=%0d expected 1/0", ok, oen_low);
        end
        checks++;
        if (bad != 0) begin
            failures++; $display("FAIL bp_hold: %0d unstable cycles expected 0", bad);
        end
        accept_rx();
        checks++;
        if (bus.RX_VALID !== 1'b0 || bus.OEN !== 1'b1) begin
            failures++; $display("FAIL bp_accept: valid=%b oen=%b expected 0/1", bus.RX_VALID, bus.OEN);
        end
        tick();
        bus.RXRDY = 1'b0;
        checks++;
        if (bus.OEN !== 1'b0) begin
            failures++; $display("FAIL bp_read_resume: oen=%b expected 0", bus.OEN);
        end
        for (int k = 1; k < RD_HOLD; k++) tick();
        tick();
        checks++;
        if (bus.RX_VALID !== 1'b1 || bus.RX_DATA !== 8'h43) begin
            failures++; $display("FAIL bp_second_byte: valid=%b data=%h expected 1/43", bus.RX_VALID, bus.RX_DATA);
        end
        accept_rx();
    endtask

    task automatic test_random();
        logic [7:0]  tx_src[$];
        logic [10:0] rx_src[$];
        logic [7:0]  wr_got[$];
        logic [10:0] rx_got[$];
        logic [2:0]  f;
        int tx_idx = 0, rx_idx = 0, exp_err = 0;
        int viol = 0, bad_run = 0, run = 0, last_wr = -1, min_sp = 1000;
        int bad_tx = 0, bad_rx = 0;
        bit drop = 1'b0, done = 1'b0;
        settle();
        bus.CLR_ERR = 1'b1;
        tick();
        bus.CLR_ERR = 1'b0;
        for (int i = 0; i < N_RAND; i++) begin
            tx_src.push_back(8'($urandom));
            f = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            rx_src.push_back({f, 8'($urandom)});
            if (f != 3'b000) exp_err++;
        end
        for (int cyc = 0; cyc < 6000 && !done; cyc++) begin
            tick();
            if (drop) begin
                tx_idx++;
                bus.TX_VALID = 1'b0;
                drop = 1'b0;
            end
            if (!bus.TX_VALID && tx_idx < N_RAND && $urandom_range(0, 3) != 0) begin
                bus.TX_VALID = 1'b1;
                bus.TX_DATA  = tx_src[tx_idx];
            end
            bus.TXRDY    = ($urandom_range(0, 3) != 0);
            bus.RX_READY = ($urandom_range(0, 2) != 0);
            bus.RXRDY    = (rx_idx < N_RAND);
            if (rx_idx < N_RAND) {bus.FRAMING_ERR, bus.PARITY_ERR, bus.OVERFLOW, bus.UART_DOUT} = rx_src[rx_idx];
            if (bus.WEN === 1'b0 && bus.OEN === 1'b0) viol++;
            if (bus.WEN === 1'b0) begin
                wr_got.push_back(bus.UART_DIN);
                if (last_wr >= 0 && cyc - last_wr < min_sp) min_sp = cyc - last_wr;
                last_wr = cyc;
            end
            if (bus.OEN === 1'b0) begin
                run++;
            end else if (run > 0) begin
                if (run != RD_HOLD) bad_run++;
                run = 0;
                rx_idx++;
            end
            if (bus.RX_VALID === 1'b1 && bus.RX_READY) rx_got.push_back({bus.RX_ERR, bus.RX_DATA});
            if (bus.TX_VALID && bus.TX_READY === 1'b1) drop = 1'b1;
            done = (wr_got.size() == N_RAND) && (rx_got.size() == N_RAND);
        end
        tick();
        idle_inputs();
        checks++;
        if (!done) begin
            failures++; $display("FAIL rand_timeout: writes=%0d reads=%0d expected %0d each", wr_got.size(), rx_got.size(), N_RAND);
        end
        for (int i = 0; i < N_RAND; i++) begin
            if (i >= wr_got.size() || wr_got[i] !== tx_src[i]) bad_tx++;
            if (i >= rx_got.size() || rx_got[i] !== rx_src[i]) bad_rx++;
        end
        checks++;
        if (bad_tx != 0 || wr_got.size() != N_RAND) begin
            failures++; $display("FAIL rand_tx_stream: %0d wrong of %0d (got %0d writes)", bad_tx, N_RAND, wr_got.size());
        end
        checks++;
        if (bad_rx != 0 || rx_got.size() != N_RAND) begin
            failures++; $display("FAIL rand_rx_stream: %0d wrong of %0d (got %0d bytes)", bad_rx, N_RAND, rx_got.size());
        end
        checks++;
        if (viol != 0 || bad_run != 0) begin
            failures++; $display("FAIL rand_strobes: overlap=%0d bad_read_len=%0d expected 0/0", viol, bad_run);
        end
        checks++;
        if (min_sp < WR_SPACING) begin
            failures++; $display("FAIL rand_spacing: min write spacing %0d expected >= %0d", min_sp, WR_SPACING);
        end
        checks++;
        if (bus.ERR_CNT !== ERR_CNT_W'(exp_err)) begin
            failures++; $display("FAIL rand_err_cnt: got %0d expected %0d", bus.ERR_CNT, exp_err);
        end
    endtask

    initial begin
        RESET = 1'b1;
        idle_inputs();
        test_reset();
        test_write();
        test_back_to_back();
        test_tx_drop();
        test_read();
        test_priority();
        test_err_sat();
        test_reset_mid_read();
        test_rx_backpressure();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end
endmodule
